// File: rtl/drive_pkg.sv
`default_nettype none
// ============================================================================
// Package  : drive_pkg
// Purpose  : Motor command codes, arbiter state encoding and command helpers.
// Revision : 1.0 - initial release
// ============================================================================
package drive_pkg;

    localparam logic [2:0] c_CMD_STOP  = 3'b000;
    localparam logic [2:0] c_CMD_FWD   = 3'b001;
    localparam logic [2:0] c_CMD_BACK  = 3'b010;
    localparam logic [2:0] c_CMD_LEFT  = 3'b101;
    localparam logic [2:0] c_CMD_RIGHT = 3'b110;

    localparam logic [2:0] c_ST_IDLE       = 3'b000;
    localparam logic [2:0] c_ST_LINE       = 3'b001;
    localparam logic [2:0] c_ST_REMOTE     = 3'b010;
    localparam logic [2:0] c_ST_AVOID_BACK = 3'b011;
    localparam logic [2:0] c_ST_AVOID_TURN = 3'b100;

    // Unknown remote codes are forced to STOP so the motor never sees them.
    function automatic logic [2:0] legal_cmd(input logic [2:0] raw);
        case (raw)
            c_CMD_STOP, c_CMD_FWD, c_CMD_BACK, c_CMD_LEFT, c_CMD_RIGHT: legal_cmd = raw;
            default: legal_cmd = c_CMD_STOP;
        endcase
    endfunction

    // The line follower reports 000 for "on track", which means drive forward.
    function automatic logic [2:0] line_cmd(input logic [2:0] filt);
        case (filt)
            3'b000:  line_cmd = c_CMD_FWD;
            3'b101:  line_cmd = c_CMD_LEFT;
            3'b110:  line_cmd = c_CMD_RIGHT;
            default: line_cmd = c_CMD_STOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_debounce.sv
`default_nettype none
// ============================================================================
// Module   : cmd_debounce
// Purpose  : Passes a 3-bit command through only once it has held steady.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_debounce #(
    parameter int STABLE_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_cmd,
    output logic [2:0] o_cmd
);

    localparam int              c_CW    = $clog2(STABLE_CYC) + 1;
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STABLE_CYC);
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(STABLE_CYC - 1);

    logic [2:0]      r_prev;
    logic [2:0]      r_filt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nx;

    // The edge that first sees a new value counts as one of the stable samples.
    always_comb begin
        w_cnt_nx = '0;
        if (i_cmd == r_prev) begin
            w_cnt_nx = (r_cnt < c_LIMIT) ? r_cnt + 1'b1 : r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 3'b000;
            r_filt <= 3'b000;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_cmd;
            r_cnt  <= w_cnt_nx;
            if (w_cnt_nx >= c_LAST) begin
                r_filt <= i_cmd;
            end
        end
    end

    assign o_cmd = r_filt;

endmodule
`default_nettype wire

// File: rtl/drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : drive_arbiter
// Purpose  : Chooses the motor command from obstacle, remote and line sources.
// Revision : 1.0 - initial release
// ============================================================================
module drive_arbiter #(
    parameter int STABLE_CYC  = 16,
    parameter int BT_HOLD_CYC = 5000000,
    parameter int BACK_CYC    = 25000000,
    parameter int TURN_CYC    = 15000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hw_ctr,
    input  logic [2:0] bt_cmd,
    input  logic       bt_valid,
    input  logic       obstacle,
    input  logic       mode_auto,
    output logic [2:0] motor_ctr,
    output logic [2:0] state_led,
    output logic       fault
);

    import drive_pkg::*;

    localparam int c_M1 = (STABLE_CYC > BT_HOLD_CYC) ? STABLE_CYC : BT_HOLD_CYC;
    localparam int c_M2 = (c_M1 > BACK_CYC) ? c_M1 : BACK_CYC;
    localparam int c_M3 = (c_M2 > TURN_CYC) ? c_M2 : TURN_CYC;
    localparam int c_M4 = (c_M3 > MAX_RETRY) ? c_M3 : MAX_RETRY;
    localparam int c_TW = $clog2(c_M4) + 1;

    localparam logic [c_TW-1:0] c_HOLD_LOAD = c_TW'(BT_HOLD_CYC - 1);
    localparam logic [c_TW-1:0] c_BACK_LOAD = c_TW'(BACK_CYC - 1);
    localparam logic [c_TW-1:0] c_TURN_LOAD = c_TW'(TURN_CYC - 1);
    localparam logic [c_TW-1:0] c_MAX_RETRY = c_TW'(MAX_RETRY);

    logic [2:0]      r_state, w_state_nx;
    logic [c_TW-1:0] r_timer, w_timer_nx;
    logic [c_TW-1:0] r_retry, w_retry_nx;
    logic [2:0]      r_bt_cmd, w_bt_cmd_nx;
    logic            r_fault, w_fault_nx;
    logic [2:0]      r_motor, w_motor_nx;
    logic [2:0]      w_filt;
    logic            w_enter_back;
    logic            w_moving;

    cmd_debounce #(
        .STABLE_CYC (STABLE_CYC)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .i_cmd (hw_ctr),
        .o_cmd (w_filt)
    );

    // Only a car that is actually heading somewhere is steered away.
    assign w_moving = (r_bt_cmd == c_CMD_FWD) || (r_bt_cmd == c_CMD_LEFT) ||
                      (r_bt_cmd == c_CMD_RIGHT);

    always_comb begin
        w_state_nx   = r_state;
        w_timer_nx   = (r_timer != '0) ? r_timer - 1'b1 : '0;
        w_retry_nx   = r_retry;
        w_bt_cmd_nx  = r_bt_cmd;
        w_fault_nx   = r_fault;
        w_motor_nx   = c_CMD_STOP;
        w_enter_back = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (r_fault) begin
                    if (bt_valid && (legal_cmd(bt_cmd) == c_CMD_STOP)) begin
                        w_fault_nx = 1'b0;
                    end
                end else if (mode_auto) begin
                    w_state_nx = c_ST_LINE;
                end else if (bt_valid) begin
                    w_state_nx  = c_ST_REMOTE;
                    w_bt_cmd_nx = legal_cmd(bt_cmd);
                    w_timer_nx  = c_HOLD_LOAD;
                end
            end
            c_ST_LINE: begin
                w_motor_nx = line_cmd(w_filt);
                if (obstacle) begin
                    w_enter_back = 1'b1;
                end else if (!mode_auto) begin
                    w_state_nx = c_ST_IDLE;
                end
            end
            c_ST_REMOTE: begin
                w_motor_nx = r_bt_cmd;
                if (obstacle && w_moving) begin
                    w_enter_back = 1'b1;
                end else if (mode_auto) begin
                    w_state_nx = c_ST_LINE;
                end else if (bt_valid) begin
                    w_bt_cmd_nx = legal_cmd(bt_cmd);
                    w_timer_nx  = c_HOLD_LOAD;
                end else if (r_timer == '0) begin
                    w_state_nx = c_ST_IDLE;
                end
            end
            c_ST_AVOID_BACK: begin
                w_motor_nx = c_CMD_BACK;
                if (r_timer == '0) begin
                    w_state_nx = c_ST_AVOID_TURN;
                    w_timer_nx = c_TURN_LOAD;
                end
            end
            c_ST_AVOID_TURN: begin
                w_motor_nx = c_CMD_RIGHT;
                if (r_timer == '0) begin
                    if (!obstacle) begin
                        w_retry_nx = '0;
                        w_state_nx = mode_auto ? c_ST_LINE : c_ST_IDLE;
                    end else if (r_retry < c_MAX_RETRY) begin
                        w_enter_back = 1'b1;
                    end else begin
                        w_fault_nx = 1'b1;
                        w_state_nx = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = c_ST_IDLE;
            end
        endcase

        if (w_enter_back) begin
            w_state_nx = c_ST_AVOID_BACK;
            w_timer_nx = c_BACK_LOAD;
            w_retry_nx = (r_retry != '1) ? r_retry + 1'b1 : r_retry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_timer  <= '0;
            r_retry  <= '0;
            r_bt_cmd <= c_CMD_STOP;
            r_fault  <= 1'b0;
            r_motor  <= c_CMD_STOP;
        end else begin
            r_state  <= w_state_nx;
            r_timer  <= w_timer_nx;
            r_retry  <= w_retry_nx;
            r_bt_cmd <= w_bt_cmd_nx;
            r_fault  <= w_fault_nx;
            r_motor  <= w_motor_nx;
        end
    end

    assign motor_ctr = r_motor;
    assign state_led = r_state;
    assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_drive_arbiter
// Purpose  : Directed self-checking bench for drive_arbiter with a timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drive_arbiter;

    localparam int ST = 4;
    localparam int BH = 20;
    localparam int BK = 8;
    localparam int TN = 6;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] hw_ctr;
    logic [2:0] bt_cmd;
    logic       bt_valid;
    logic       obstacle;
    logic       mode_auto;
    logic [2:0] motor_ctr;
    logic [2:0] state_led;
    logic       fault;

    int n_tests = 0;
    int n_fail  = 0;

    drive_arbiter #(
        .STABLE_CYC  (ST),
        .BT_HOLD_CYC (BH),
        .BACK_CYC    (BK),
        .TURN_CYC    (TN),
        .MAX_RETRY   (MR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hw_ctr    (hw_ctr),
        .bt_cmd    (bt_cmd),
        .bt_valid  (bt_valid),
        .obstacle  (obstacle),
        .mode_auto (mode_auto),
        .motor_ctr (motor_ctr),
        .state_led (state_led),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: phases with elapsed-cycle ages; debounce as "last ST samples equal".
    int         m_phase;
    int         m_age;
    int         m_tries;
    bit         m_fault;
    bit         m_valid = 1'b0;
    logic [2:0] m_cmd;
    logic [2:0] m_filt;
    logic [2:0] exp_motor;
    logic [2:0] hist[$];

    function automatic logic [2:0] legal(input logic [2:0] c);
        return (c inside {3'b000, 3'b001, 3'b010, 3'b101, 3'b110}) ? c : 3'b000;
    endfunction

    function automatic logic [2:0] line_map(input logic [2:0] f);
        if (f == 3'b000) return 3'b001;
        if (f == 3'b101) return 3'b101;
        if (f == 3'b110) return 3'b110;
        return 3'b000;
    endfunction

    always @(posedge clk) begin : model
        logic [2:0] mot;
        bit         to_back;
        bit         same;
        if (rst) begin
            m_phase = 0; m_age = 0; m_tries = 0; m_fault = 1'b0;
            m_cmd = 3'b000; m_filt = 3'b000; exp_motor = 3'b000;
            hist.delete();
            hist.push_back(3'b000);
            m_valid = 1'b1;
        end else begin
            case (m_phase)
                0:       mot = 3'b000;
                1:       mot = line_map(m_filt);
                2:       mot = m_cmd;
                3:       mot = 3'b010;
                default: mot = 3'b110;
            endcase
            exp_motor = mot;
            to_back = 1'b0;
            m_age++;
            case (m_phase)
                0: begin
                    if (m_fault) begin
                        if (bt_valid && legal(bt_cmd) == 3'b000) m_fault = 1'b0;
                    end else if (mode_auto) m_phase = 1;
                    else if (bt_valid) begin m_phase = 2; m_cmd = legal(bt_cmd); m_age = 0; end
                end
                1: begin
                    if (obstacle) to_back = 1'b1;
                    else if (!mode_auto) m_phase = 0;
                end
                2: begin
                    if (obstacle && m_cmd inside {3'b001, 3'b101, 3'b110}) to_back = 1'b1;
                    else if (mode_auto) m_phase = 1;
                    else if (bt_valid) begin m_cmd = legal(bt_cmd); m_age = 0; end
                    else if (m_age == BH) m_phase = 0;
                end
                3: if (m_age == BK) begin m_phase = 4; m_age = 0; end
                default: begin
                    if (m_age == TN) begin
                        if (!obstacle) begin m_tries = 0; m_phase = mode_auto ? 1 : 0; end
                        else if (m_tries < MR) to_back = 1'b1;
                        else begin m_fault = 1'b1; m_phase = 0; end
                    end
                end
            endcase
            if (to_back) begin m_phase = 3; m_age = 0; m_tries++; end
            hist.push_back(hw_ctr);
            if (hist.size() > ST) void'(hist.pop_front());
            if (hist.size() == ST) begin
                same = 1'b1;
                foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
                if (same) m_filt = hist[0];
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model motor_ctr", motor_ctr, exp_motor);
            chk("model state_led", state_led, 3'(m_phase));
            chk("model fault", {2'b00, fault}, {2'b00, m_fault});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bt_pulse(input logic [2:0] c);
        bt_cmd = c; bt_valid = 1'b1;
        cyc(1);
        bt_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hw_ctr = 3'b000; bt_cmd = 3'b000; bt_valid = 1'b0;
        obstacle = 1'b0; mode_auto = 1'b0;
        cyc(2);
        chk("reset motor", motor_ctr, 3'b000);
        chk("reset led", state_led, 3'b000);
        chk("reset fault", {2'b00, fault}, 3'b000);

        // Debounce latency and glitch rejection in LINE
        rst = 1'b0; mode_auto = 1'b1;
        cyc(8);
        chk("line fwd", motor_ctr, 3'b001);
        hw_ctr = 3'b101;
        cyc(4);
        chk("debounce not yet", motor_ctr, 3'b001);
        cyc(1);
        chk("debounce latency", motor_ctr, 3'b101);
        cyc(3);
        hw_ctr = 3'b110;
        cyc(2);
        hw_ctr = 3'b101;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("glitch suppressed", motor_ctr, 3'b101);
        end

        // Remote hold, timeout and refresh
        hw_ctr = 3'b000; mode_auto = 1'b0;
        cyc(8);
        chk("idle led", state_led, 3'b000);
        bt_pulse(3'b001);
        chk("remote led", state_led, 3'b010);
        cyc(20);
        chk("remote hold", motor_ctr, 3'b001);
        cyc(1);
        chk("remote timeout motor", motor_ctr, 3'b000);
        chk("remote timeout led", state_led, 3'b000);
        cyc(2);
        bt_pulse(3'b001);
        cyc(14);
        bt_pulse(3'b001);
        cyc(5);
        chk("refresh extends", motor_ctr, 3'b001);
        cyc(15);
        chk("refresh hold", motor_ctr, 3'b001);
        cyc(1);
        chk("refresh timeout", motor_ctr, 3'b000);

        // Single avoidance from LINE with a short obstacle
        mode_auto = 1'b1;
        cyc(3);
        chk("line fwd again", motor_ctr, 3'b001);
        obstacle = 1'b1;
        cyc(2);
        chk("avoid back start", motor_ctr, 3'b010);
        cyc(1);
        obstacle = 1'b0;
        cyc(6);
        chk("avoid back end", motor_ctr, 3'b010);
        cyc(1);
        chk("avoid turn start", motor_ctr, 3'b110);
        cyc(5);
        chk("avoid turn end", motor_ctr, 3'b110);
        cyc(1);
        chk("avoid resume line", motor_ctr, 3'b001);
        chk("avoid no fault", {2'b00, fault}, 3'b000);

        // Persistent obstacle exhausts retries, then fault clear
        obstacle = 1'b1;
        cyc(32);
        chk("fault set", {2'b00, fault}, 3'b001);
        chk("fault motor", motor_ctr, 3'b000);
        chk("fault led", state_led, 3'b000);
        obstacle = 1'b0;
        bt_pulse(3'b000);
        chk("fault cleared", {2'b00, fault}, 3'b000);
        chk("fault clear stays idle", state_led, 3'b000);

        // Reset in the middle of AVOID_BACK
        cyc(8);
        obstacle = 1'b1;
        cyc(1);
        obstacle = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst mid avoid motor", motor_ctr, 3'b000);
        chk("rst mid avoid led", state_led, 3'b000);
        obstacle = 1'b1;
        cyc(20);
        chk("retry cleared by rst", {2'b00, fault}, 3'b000);
        cyc(20);
        chk("fault after two runs", {2'b00, fault}, 3'b001);
        rst = 1'b1; obstacle = 1'b0; mode_auto = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(2);

        // Illegal remote code, reversing ignored, simultaneous events
        bt_pulse(3'b111);
        cyc(1);
        chk("illegal cmd stop", motor_ctr, 3'b000);
        chk("illegal cmd remote", state_led, 3'b010);
        bt_pulse(3'b010);
        obstacle = 1'b1;
        cyc(3);
        chk("reverse not avoided led", state_led, 3'b010);
        chk("reverse motor", motor_ctr, 3'b010);
        obstacle = 1'b0;
        bt_pulse(3'b001);
        cyc(2);
        chk("remote fwd", motor_ctr, 3'b001);
        bt_cmd = 3'b001; bt_valid = 1'b1; mode_auto = 1'b1; obstacle = 1'b1;
        cyc(1);
        bt_valid = 1'b0; obstacle = 1'b0; mode_auto = 1'b0;
        chk("obstacle wins", state_led, 3'b011);
        cyc(20);
        chk("sequence ends idle", state_led, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/drive_arbiter.md
Name: drive_arbiter

Overview:
- Central motion controller of the smart car: decides the one 3-bit command driven to the motor block.
- Sources, highest priority first: obstacle sensor, Bluetooth remote, infrared line follower.
- Debounces the line-follower command, times out stale remote commands, and runs a timed back-off/turn sequence when an obstacle appears.
- Sits between the sensor/receiver front-ends and the motor PWM module.

Parameters:
- STABLE_CYC, 16: consecutive identical line-follower samples required before the filtered command updates.
- BT_HOLD_CYC, 5000000: cycles a remote command is held without a refresh (100 ms at 50 MHz).
- BACK_CYC, 25000000: cycles reversing in the avoidance sequence.
- TURN_CYC, 15000000: cycles turning right in the avoidance sequence.
- MAX_RETRY, 3: avoidance attempts before declaring a fault.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- hw_ctr  in  3  line-follower command: 000 = straight, 101 = left, 110 = right
- bt_cmd  in  3  remote command, sampled only when bt_valid = 1
- bt_valid  in  1  single-cycle strobe for a new remote command
- obstacle  in  1  1 = obstacle ahead (already synchronised)
- mode_auto  in  1  1 = line-follow mode, 0 = remote mode
- motor_ctr  out  3  command to motor block, registered
- state_led  out  3  current state encoding
- fault  out  1  avoidance retries exhausted

Behaviour:
- Command codes:
  - STOP = 000, FWD = 001, BACK = 010, LEFT = 101, RIGHT = 110.
  - Any other bt_cmd value is treated as STOP.
- Reset (rst high at a clk edge):
  - state = IDLE; motor_ctr = 000; state_led = 000; fault = 0.
  - Filtered command = 000; all counters and the retry count = 0; latched remote command = STOP.
  - Reset mid-sequence aborts the sequence immediately.
- Debounce:
  - A stability counter clears whenever hw_ctr differs from its previous-cycle sample.
  - When hw_ctr has been unchanged for STABLE_CYC consecutive edges, filt_ctr takes that value.
  - Latency from a hw_ctr change to motor_ctr is STABLE_CYC+1 cycles while in LINE.
- Output mapping:
  - All outputs are registered; motor_ctr reflects the state and inputs of the previous edge.
  - In LINE: filt 000 -> FWD, 101 -> LEFT, 110 -> RIGHT, any other value -> STOP.
- States (state_led encoding):
  - IDLE = 000, LINE = 001, REMOTE = 010, AVOID_BACK = 011, AVOID_TURN = 100.
- IDLE (motor STOP):
  - If fault = 1, stay in IDLE.
  - Else if mode_auto = 1, go to LINE.
  - Else if bt_valid = 1, go to REMOTE, latch the command, load the hold timer.
- LINE:
  - motor = mapped filt_ctr.
  - mode_auto = 0 -> IDLE.
  - obstacle = 1 -> AVOID_BACK; this takes priority over the mode change.
- REMOTE:
  - motor = latched command.
  - bt_valid = 1 relatches the command and reloads the timer to BT_HOLD_CYC.
  - Timer reaching 0 -> IDLE.
  - mode_auto = 1 -> LINE.
  - obstacle = 1 -> AVOID_BACK only when the latched command is FWD, LEFT or RIGHT; reversing or stopped is left alone.
  - Priority when several fire together: obstacle > mode change > bt_valid > timeout.
- AVOID_BACK:
  - motor BACK; lasts exactly BACK_CYC cycles, then AVOID_TURN.
  - Retry count increments on entry.
- AVOID_TURN:
  - motor RIGHT for TURN_CYC cycles.
  - At expiry, if obstacle = 0: clear the retry count, go to LINE if mode_auto = 1, else IDLE.
  - At expiry, if obstacle = 1 and retries < MAX_RETRY: go to AVOID_BACK.
  - At expiry, if obstacle = 1 and retries = MAX_RETRY: set fault = 1, go to IDLE.
- Rules during avoidance:
  - bt_valid and mode_auto are ignored for the whole sequence; the sequence is not interruptible except by rst.
- Fault:
  - Cleared by rst, or by bt_valid with bt_cmd = STOP while in IDLE.
  - The clearing event only clears fault; the state stays IDLE.
- Counter widths: use $clog2 of the largest parameter plus 1; counters saturate and never wrap.

Decomposition:
- Package drive_pkg holds:
  - the command code constants STOP/FWD/BACK/LEFT/RIGHT;
  - the state encoding constants;
  - a function mapping a raw 3-bit command to a legal code.
- One sub-module, cmd_debounce (parameter STABLE_CYC, 3-bit in/out, clk/rst), implements the filter.
- Everything else stays in drive_arbiter.

Test Plan:
All tests use overrides STABLE_CYC=4, BT_HOLD_CYC=20, BACK_CYC=8, TURN_CYC=6, MAX_RETRY=2.
- Reset, then mode_auto=1 and hw_ctr=101 held -> motor_ctr = 101 exactly 5 cycles after the hw_ctr change; a 2-cycle glitch to 110 -> motor_ctr never shows 110.
- mode_auto=0, bt_valid pulse with bt_cmd=001 -> state REMOTE, motor 001 for 20 cycles, then 000 and state IDLE; refresh at cycle 15 -> motor stays 001 until cycle 35.
- LINE with FWD, obstacle=1 for 3 cycles -> motor 010 for 8 cycles, then 110 for 6 cycles, then back to mapped filt_ctr; fault stays 0.
- obstacle held at 1 -> BACK/TURN runs twice, then fault=1, motor 000, state IDLE; bt_valid with cmd 000 -> fault=0.
- Assert rst during AVOID_BACK cycle 3 -> next edge motor 000, state_led 000, retry count 0.
- REMOTE with bt_cmd=111 -> motor 000; bt_valid, mode_auto 0->1 and obstacle all on one edge with latched FWD -> state AVOID_BACK.
